// File: rtl/chaos_stream_cipher.sv
// Key-word consumer for the chaos generator: fetches 4 key bytes per STEP and XORs the byte stream with them.
// One-cycle latency, 1 byte/cycle within a word; IN_READY drops while OUT is stalled or a new word is fetched.
module chaos_stream_cipher #(
   parameter int TIMEOUT    = 255,
   parameter int RST_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        SESSION_START,
   input  logic [31:0] SEED,
   output logic [31:0] KEY_SHIFT,
   output logic        KEY_RESET,
   output logic        KEY_STEP,
   input  logic        KEY_DONE,
   input  logic [7:0]  KEY_X,
   input  logic [7:0]  KEY_Y,
   input  logic [7:0]  KEY_Z,
   input  logic [7:0]  KEY_W,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [7:0]  IN_DATA,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [7:0]  OUT_DATA,
   output logic        ERR
);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_REQ, S_LATCH, S_REL, S_SERVE
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
   localparam logic [7:0] RST_C     = 8'(RST_CYCLES);

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       rel_low, rel_low_nxt;
   logic       timeout_hit;
   logic [7:0] key [4];
   logic [1:0] idx;
   logic       avail;
   logic       in_acc;
   logic       last_byte;

   // A session restart in the same cycle always wins over an accept.
   assign IN_READY  = (state == S_SERVE) & avail & (!OUT_VALID | OUT_READY) & !SESSION_START;
   assign in_acc    = IN_VALID & IN_READY;
   assign last_byte = in_acc & (idx == 2'd3);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= S_IDLE;
         cnt     <= 8'd0;
         rel_low <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         rel_low <= rel_low_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      rel_low_nxt = rel_low;
      KEY_RESET   = 1'b0;
      KEY_STEP    = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE: ;
         S_INIT: begin
            KEY_RESET = (cnt < RST_C);
            if (cnt == RST_C) begin
               state_nxt = S_REQ;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         S_REQ: begin
            KEY_STEP = !SESSION_START;
            if (KEY_DONE) begin
               state_nxt = S_LATCH;
            end else if (cnt == TIMEOUT_C) begin
               timeout_hit = 1'b1;
               state_nxt   = S_IDLE;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         S_LATCH: begin
            state_nxt   = S_REL;
            rel_low_nxt = 1'b0;
         end
         // Wait for the generator to drop DONE, then one more quiet cycle.
         S_REL: begin
            if (rel_low) state_nxt = S_SERVE;
            else if (!KEY_DONE) rel_low_nxt = 1'b1;
         end
         S_SERVE: begin
            if (last_byte) begin
               state_nxt = S_REQ;
               cnt_nxt   = 8'd0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (SESSION_START) begin
         state_nxt   = S_INIT;
         cnt_nxt     = 8'd0;
         timeout_hit = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         KEY_SHIFT <= 32'd0;
         OUT_VALID <= 1'b0;
         OUT_DATA  <= 8'd0;
         ERR       <= 1'b0;
         avail     <= 1'b0;
         idx       <= 2'd0;
         for (int i = 0; i < 4; i++) key[i] <= 8'd0;
      end else begin
         if (SESSION_START) begin
            KEY_SHIFT <= SEED;
            ERR       <= 1'b0;
            avail     <= 1'b0;
            idx       <= 2'd0;
         end else begin
            if (timeout_hit) ERR <= 1'b1;
            if (state == S_REQ && KEY_DONE) begin
               key[0] <= KEY_X;
               key[1] <= KEY_Y;
               key[2] <= KEY_Z;
               key[3] <= KEY_W;
            end
            if (state == S_LATCH) begin
               idx   <= 2'd0;
               avail <= 1'b1;
            end
            if (in_acc) begin
               idx <= idx + 2'd1;
               if (idx == 2'd3) avail <= 1'b0;
            end
         end
         // A registered byte survives a session restart.
         if (in_acc) begin
            OUT_DATA  <= IN_DATA ^ key[idx];
            OUT_VALID <= 1'b1;
         end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
         end
      end
   end

endmodule
